zoran_nios_clocks_pll_supervisor: RTL and testbench

ZORAN_NIOS_CLOCKS_PLL_SUPERVISOR -- requirements
Module: zoran_nios_clocks_pll_supervisor

---
 rtl/zoran_nios_clocks_pll_supervisor.sv | 164 ++++++++++++++++
 tb/tb_zoran_nios_clocks_pll_supervisor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/zoran_nios_clocks_pll_supervisor.sv
`timescale 1ns/1ps
// PLL bring-up supervisor: pulses the PLL reset, waits for a stable lock,
// holds the downstream system in reset for a short settle time, then
// releases it. Lock loss while running restarts the sequence and is
// tallied in relock_count. A lock timeout re-issues the PLL reset and
// leaves a sticky timeout_err behind.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_PLL_RST   | pll_rst driven high for PLL_RST_CYCLES cycles
// ST_WAIT_LOCK | waiting for lk_s, bounded by LOCK_TIMEOUT_CYCLES
// ST_STABILIZE | counting consecutive locked cycles up to LOCK_STABLE_CYCLES
// ST_HOLD      | locked; sys_reset still held for RESET_HOLD_CYCLES
// ST_RUN       | system released; watching for lock loss
module zoran_nios_clocks_pll_supervisor #(
    parameter int PLL_RST_CYCLES      = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES   = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       sys_ready,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD     = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    // The counter only ever reaches MAX_CYCLES-1 before its terminal compare
    // fires, so this width can never overflow.
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lk_meta;
    logic             lk_s;
    logic             timeout_hit;
    logic             lock_lost_run;

    // Two-flop synchronizer; lk_s is the only view of pll_locked the FSM has.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // Next-state and shared counter update.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        timeout_hit   = 1'b0;
        lock_lost_run = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == PLL_RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    state_nxt = ST_STABILIZE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = ST_PLL_RST;
                    cnt_nxt     = '0;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_STABILIZE: begin
                if (!lk_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_HOLD: begin
                // Lock loss here is part of bring-up, not a relock event.
                if (!lk_s) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_nxt     = ST_PLL_RST;
                    cnt_nxt       = '0;
                    lock_lost_run = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs decode the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= ST_PLL_RST;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            sys_reset    <= 1'b1;
            sys_ready    <= 1'b0;
            relock_count <= 8'd0;
            timeout_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pll_rst   <= (state_nxt == ST_PLL_RST);
            sys_reset <= (state_nxt != ST_RUN);
            sys_ready <= (state_nxt == ST_RUN);
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (lock_lost_run && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_zoran_nios_clocks_pll_supervisor.sv
`timescale 1ns/1ps
// Directed bench for the PLL supervisor. Stimulus schedules expected output
// values at future cycles into a scoreboard queue; a monitor on the falling
// edge compares every entry that comes due.
module tb_zoran_nios_clocks_pll_supervisor;

    localparam int SEL_PLL_RST = 0;
    localparam int SEL_SYS_RST = 1;
    localparam int SEL_READY   = 2;
    localparam int SEL_RELOCK  = 3;
    localparam int SEL_TIMEOUT = 4;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       sys_ready;
    logic [7:0] relock_count;
    logic       timeout_err;

    typedef struct {
        string name;
        int    due;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    zoran_nios_clocks_pll_supervisor #(
        .PLL_RST_CYCLES     (3),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .sys_ready   (sys_ready),
        .relock_count(relock_count),
        .timeout_err (timeout_err)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Rising-edge count; at a falling edge cyc equals the edges seen so far.
    always @(posedge refclk) cyc <= cyc + 1;

    function automatic int observe(int sel);
        case (sel)
            SEL_PLL_RST: return int'(pll_rst);
            SEL_SYS_RST: return int'(sys_reset);
            SEL_READY:   return int'(sys_ready);
            SEL_RELOCK:  return int'(relock_count);
            default:     return int'(timeout_err);
        endcase
    endfunction

    // Schedule an expected value `off` falling edges from now.
    function automatic void sched(string name, int off, int sel, int exp);
        exp_t e;
        e.name = name;
        e.due  = cyc + off;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    // Monitor: compare every expectation that falls due on this edge.
    always @(negedge refclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                n_vec++;
                if (observe(sb[i].sel) != sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                             sb[i].name, observe(sb[i].sel), sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    // Drop lock in RUN, restore it after the PLL reset pulse, return to RUN.
    // Starts and ends on a falling edge with the DUT in RUN (21 cycles).
    task automatic lose_and_relock();
        pll_locked = 1'b0;
        repeat (6) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (15) @(negedge refclk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        repeat (3) @(negedge refclk);

        // Reset state.
        sched("reset pll_rst",      1, SEL_PLL_RST, 1);
        sched("reset sys_reset",    1, SEL_SYS_RST, 1);
        sched("reset sys_ready",    1, SEL_READY,   0);
        sched("reset relock_count", 1, SEL_RELOCK,  0);
        sched("reset timeout_err",  1, SEL_TIMEOUT, 0);
        @(negedge refclk);

        // Normal bring-up with lock held high.
        rst = 1'b0;
        sched("bringup pll_rst@1",    1, SEL_PLL_RST, 1);
        sched("bringup pll_rst@2",    2, SEL_PLL_RST, 1);
        sched("bringup pll_rst@3",    3, SEL_PLL_RST, 0);
        sched("bringup sys_reset@15", 15, SEL_SYS_RST, 1);
        sched("bringup sys_reset@16", 16, SEL_SYS_RST, 0);
        sched("bringup sys_ready@15", 15, SEL_READY,   0);
        sched("bringup sys_ready@16", 16, SEL_READY,   1);
        sched("bringup relock",       16, SEL_RELOCK,  0);
        sched("bringup timeout_err",  16, SEL_TIMEOUT, 0);
        repeat (17) @(negedge refclk);

        // Single lock loss in RUN.
        sched("loss sys_reset@2", 2, SEL_SYS_RST, 0);
        sched("loss sys_reset@3", 3, SEL_SYS_RST, 1);
        sched("loss pll_rst@3",   3, SEL_PLL_RST, 1);
        sched("loss pll_rst@5",   5, SEL_PLL_RST, 1);
        sched("loss pll_rst@6",   6, SEL_PLL_RST, 0);
        sched("loss relock@3",    3, SEL_RELOCK,  1);
        sched("loss ready@20",    20, SEL_READY,  0);
        sched("loss ready@21",    21, SEL_READY,  1);
        lose_and_relock();

        // One-cycle glitch after five stable cycles in STABILIZE.
        rst = 1'b1;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        sched("glitch pll_rst@3",    3,  SEL_PLL_RST, 0);
        sched("glitch pll_rst@11",   11, SEL_PLL_RST, 0);
        sched("glitch pll_rst@15",   15, SEL_PLL_RST, 0);
        sched("glitch sys_reset@16", 16, SEL_SYS_RST, 1);
        sched("glitch sys_reset@22", 22, SEL_SYS_RST, 1);
        sched("glitch ready@22",     22, SEL_READY,   0);
        sched("glitch ready@23",     23, SEL_READY,   1);
        repeat (7) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        repeat (15) @(negedge refclk);

        // Lock timeouts with pll_locked held low.
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        sched("timeout err@34",      34, SEL_TIMEOUT, 0);
        sched("timeout err@35",      35, SEL_TIMEOUT, 1);
        sched("timeout pll_rst@34",  34, SEL_PLL_RST, 0);
        sched("timeout pll_rst@35",  35, SEL_PLL_RST, 1);
        sched("timeout pll_rst@37",  37, SEL_PLL_RST, 1);
        sched("timeout pll_rst@38",  38, SEL_PLL_RST, 0);
        sched("timeout2 pll_rst@69", 69, SEL_PLL_RST, 0);
        sched("timeout2 pll_rst@70", 70, SEL_PLL_RST, 1);
        sched("timeout2 pll_rst@72", 72, SEL_PLL_RST, 1);
        sched("timeout2 pll_rst@73", 73, SEL_PLL_RST, 0);
        sched("timeout2 err sticky", 73, SEL_TIMEOUT, 1);
        sched("timeout sys_reset",   60, SEL_SYS_RST, 1);
        repeat (75) @(negedge refclk);

        // Lock arrives in WAIT_LOCK after the timeouts.
        pll_locked = 1'b1;
        sched("late lock ready@14", 14, SEL_READY,   0);
        sched("late lock ready@15", 15, SEL_READY,   1);
        sched("late lock err kept", 15, SEL_TIMEOUT, 1);
        repeat (15) @(negedge refclk);

        // Five relocks, then a one-cycle reset in RUN.
        for (int i = 0; i < 5; i++) lose_and_relock();
        sched("pre-reset relock",    1, SEL_RELOCK,  5);
        sched("pre-reset err",       1, SEL_TIMEOUT, 1);
        sched("pre-reset sys_reset", 1, SEL_SYS_RST, 0);
        @(negedge refclk);
        rst = 1'b1;
        sched("midrst pll_rst",     1, SEL_PLL_RST, 1);
        sched("midrst sys_reset",   1, SEL_SYS_RST, 1);
        sched("midrst sys_ready",   1, SEL_READY,   0);
        sched("midrst relock",      1, SEL_RELOCK,  0);
        sched("midrst timeout_err", 1, SEL_TIMEOUT, 0);
        sched("midrst pll_rst+1",   2, SEL_PLL_RST, 1);
        @(negedge refclk);
        rst = 1'b0;
        sched("rebringup ready@16", 16, SEL_READY, 1);
        repeat (16) @(negedge refclk);

        // 300 lock losses; relock_count saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            if (i == 1)   sched("sat relock@1",   3, SEL_RELOCK, 1);
            if (i == 254) sched("sat relock@254", 3, SEL_RELOCK, 254);
            if (i == 255) sched("sat relock@255", 3, SEL_RELOCK, 255);
            if (i == 256) sched("sat relock@256", 3, SEL_RELOCK, 255);
            if (i == 300) sched("sat relock@300", 3, SEL_RELOCK, 255);
            lose_and_relock();
        end
        sched("sat final ready", 1, SEL_READY,   1);
        sched("sat final err",   1, SEL_TIMEOUT, 0);
        repeat (3) @(negedge refclk);

        if (sb.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations never came due, expected 0",
                     sb.size());
            n_vec += sb.size();
            n_err += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
